// File: rtl/sfif_cr_pkg.sv
// Shared definitions for the SFIF receive-side credit release block.
package sfif_cr_pkg;

   // TLP class encodings as presented on tlp_type; 2'b11 is reserved.
   localparam logic [1:0] TLP_P   = 2'b00;
   localparam logic [1:0] TLP_NP  = 2'b01;
   localparam logic [1:0] TLP_CPL = 2'b10;

   // Posted-data release state machine.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      DRAIN = 2'b10
   } pd_state_e;

   // Data credits (16 bytes each) for a payload of len DW; len 0 means 1024 DW.
   function automatic logic [8:0] data_credits(input logic [9:0] len);
      logic [10:0] sum_v;
      sum_v = {1'b0, len} + 11'd3;
      if (len == 10'd0) begin
         data_credits = 9'd256;
      end else begin
         data_credits = sum_v[10:2];
      end
   endfunction

endpackage

// File: rtl/sfif_cr_cnt.sv
// Saturating pending-credit counter: adds up to 256 and removes at most one per cycle.
module sfif_cr_cnt
   import sfif_cr_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic             clk_125,
   input  logic             rst,
   input  logic [8:0]       inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             nonzero,
   output logic             sat
);

   localparam logic [CNT_W:0] MAX_C  = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W:0] ZERO_C = {(CNT_W+1){1'b0}};
   localparam logic [CNT_W:0] ONE_C  = {{CNT_W{1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W:0]   sum_s;
   logic [CNT_W:0]   diff_s;

   // Net the arrival and the return, then clamp at full scale.
   always_comb begin
      sum_s   = {1'b0, cnt_r} + {{(CNT_W-8){1'b0}}, inc};
      nonzero = (sum_s != ZERO_C);
      if (dec && nonzero) begin
         diff_s = sum_s - ONE_C;
      end else begin
         diff_s = sum_s;
      end
      if (diff_s > MAX_C) begin
         sat       = 1'b1;
         cnt_nxt_s = MAX_C[CNT_W-1:0];
      end else begin
         sat       = 1'b0;
         cnt_nxt_s = diff_s[CNT_W-1:0];
      end
   end

   // Pending-credit state register.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/sfif_cr.sv
// Receive flow-control credit release: returns consumed-TLP credits as one-credit pulses,
// batching posted-data credits to limit UpdateFC traffic.
module sfif_cr
   import sfif_cr_pkg::*;
#(
   parameter int PD_BATCH  = 8,
   parameter int FLUSH_CYC = 64,
   parameter int CNT_W     = 12
) (
   input  logic       clk_125,
   input  logic       rst,
   input  logic       tlp_done,
   input  logic [1:0] tlp_type,
   input  logic       tlp_has_data,
   input  logic [9:0] tlp_len,
   output logic       ph_cr,
   output logic       pd_cr,
   output logic       nph_cr,
   output logic       npd_cr,
   output logic       pend_empty,
   output logic       cr_overflow
);

   localparam int             TMR_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_END = TMR_W'(FLUSH_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0] BATCH_C = (CNT_W+1)'(PD_BATCH);
   localparam logic [CNT_W:0] ZERO_C  = {(CNT_W+1){1'b0}};
   localparam logic [CNT_W:0] ONE_C   = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CZ_C  = {CNT_W{1'b0}};

   logic [8:0]       inc_ph_s, inc_pd_s, inc_nph_s, inc_npd_s;
   logic [CNT_W-1:0] cnt_ph_s, cnt_pd_s, cnt_nph_s, cnt_npd_s;
   logic             nz_ph_s, nz_pd_s, nz_nph_s, nz_npd_s;
   logic             sat_ph_s, sat_pd_s, sat_nph_s, sat_npd_s;
   logic             dec_pd_s;
   logic [CNT_W:0]   pd_sum_s;
   logic             empty_nxt_s;

   pd_state_e        state_r, state_nxt_s;
   logic [TMR_W-1:0] timer_r, timer_nxt_s;

   logic ph_cr_r, pd_cr_r, nph_cr_r, npd_cr_r, pend_empty_r, cr_overflow_r;

   // Decode the consumed TLP into per-type credit increments.
   always_comb begin
      inc_ph_s  = 9'd0;
      inc_pd_s  = 9'd0;
      inc_nph_s = 9'd0;
      inc_npd_s = 9'd0;
      if (tlp_done) begin
         case (tlp_type)
            TLP_P: begin
               inc_ph_s = 9'd1;
               if (tlp_has_data) begin
                  inc_pd_s = data_credits(tlp_len);
               end else begin
                  inc_pd_s = 9'd0;
               end
            end
            TLP_NP: begin
               inc_nph_s = 9'd1;
               if (tlp_has_data) begin
                  inc_npd_s = 9'd1;
               end else begin
                  inc_npd_s = 9'd0;
               end
            end
            default: begin
               inc_ph_s = 9'd0;
            end
         endcase
      end else begin
         inc_ph_s = 9'd0;
      end
   end

   sfif_cr_cnt #(.CNT_W(CNT_W)) u_ph (
      .clk_125(clk_125), .rst(rst), .inc(inc_ph_s), .dec(nz_ph_s),
      .cnt(cnt_ph_s), .nonzero(nz_ph_s), .sat(sat_ph_s));
   sfif_cr_cnt #(.CNT_W(CNT_W)) u_pd (
      .clk_125(clk_125), .rst(rst), .inc(inc_pd_s), .dec(dec_pd_s),
      .cnt(cnt_pd_s), .nonzero(nz_pd_s), .sat(sat_pd_s));
   sfif_cr_cnt #(.CNT_W(CNT_W)) u_nph (
      .clk_125(clk_125), .rst(rst), .inc(inc_nph_s), .dec(nz_nph_s),
      .cnt(cnt_nph_s), .nonzero(nz_nph_s), .sat(sat_nph_s));
   sfif_cr_cnt #(.CNT_W(CNT_W)) u_npd (
      .clk_125(clk_125), .rst(rst), .inc(inc_npd_s), .dec(nz_npd_s),
      .cnt(cnt_npd_s), .nonzero(nz_npd_s), .sat(sat_npd_s));

   // Posted-data batching: the drain begins on the same edge that meets the
   // batch/flush condition, so the first pd_cr shows up one cycle later.
   always_comb begin
      pd_sum_s    = {1'b0, cnt_pd_s} + {{(CNT_W-8){1'b0}}, inc_pd_s};
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      dec_pd_s    = 1'b0;
      case (state_r)
         IDLE: begin
            timer_nxt_s = {TMR_W{1'b0}};
            if (pd_sum_s != ZERO_C) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            if ((pd_sum_s >= BATCH_C) || (timer_r == TMR_END)) begin
               dec_pd_s = 1'b1;
               if (pd_sum_s <= ONE_C) begin
                  state_nxt_s = IDLE;
                  timer_nxt_s = {TMR_W{1'b0}};
               end else begin
                  state_nxt_s = DRAIN;
               end
            end else begin
               timer_nxt_s = timer_r + TMR_ONE;
               state_nxt_s = ACCUM;
            end
         end
         DRAIN: begin
            dec_pd_s = 1'b1;
            if (pd_sum_s <= ONE_C) begin
               state_nxt_s = IDLE;
               timer_nxt_s = {TMR_W{1'b0}};
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            timer_nxt_s = {TMR_W{1'b0}};
         end
      endcase
      empty_nxt_s = (cnt_ph_s == CZ_C)  && (inc_ph_s == 9'd0)  &&
                    (cnt_pd_s == CZ_C)  && (inc_pd_s == 9'd0)  &&
                    (cnt_nph_s == CZ_C) && (inc_nph_s == 9'd0) &&
                    (cnt_npd_s == CZ_C) && (inc_npd_s == 9'd0);
   end

   // FSM, timer and registered credit pulses / status.
   always_ff @(posedge clk_125 or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         timer_r       <= {TMR_W{1'b0}};
         ph_cr_r       <= 1'b0;
         pd_cr_r       <= 1'b0;
         nph_cr_r      <= 1'b0;
         npd_cr_r      <= 1'b0;
         pend_empty_r  <= 1'b1;
         cr_overflow_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         timer_r       <= timer_nxt_s;
         ph_cr_r       <= nz_ph_s;
         pd_cr_r       <= dec_pd_s & nz_pd_s;
         nph_cr_r      <= nz_nph_s;
         npd_cr_r      <= nz_npd_s;
         pend_empty_r  <= empty_nxt_s;
         cr_overflow_r <= cr_overflow_r | sat_ph_s | sat_pd_s | sat_nph_s | sat_npd_s;
      end
   end

   assign ph_cr       = ph_cr_r;
   assign pd_cr       = pd_cr_r;
   assign nph_cr      = nph_cr_r;
   assign npd_cr      = npd_cr_r;
   assign pend_empty  = pend_empty_r;
   assign cr_overflow = cr_overflow_r;

endmodule

// File: tb/tb_sfif_cr.sv
// Directed testbench for sfif_cr with default parameters (PD_BATCH 8, FLUSH_CYC 64, CNT_W 12).
module tb_sfif_cr;

   logic       clk_125;
   logic       rst;
   logic       tlp_done;
   logic [1:0] tlp_type;
   logic       tlp_has_data;
   logic [9:0] tlp_len;
   logic       ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow;

   int nvec = 0;
   int nerr = 0;

   sfif_cr dut (
      .clk_125(clk_125), .rst(rst), .tlp_done(tlp_done), .tlp_type(tlp_type),
      .tlp_has_data(tlp_has_data), .tlp_len(tlp_len), .ph_cr(ph_cr), .pd_cr(pd_cr),
      .nph_cr(nph_cr), .npd_cr(npd_cr), .pend_empty(pend_empty), .cr_overflow(cr_overflow));

   initial begin
      clk_125 = 1'b0;
      forever #4 clk_125 = ~clk_125;
   end

   // Advance to 1 ns after the next rising edge: outputs are sampled and inputs driven here.
   task automatic tick();
      @(posedge clk_125);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic d, input logic [9:0] l);
      tlp_done     = 1'b1;
      tlp_type     = t;
      tlp_has_data = d;
      tlp_len      = l;
   endtask

   task automatic quiet();
      tlp_done     = 1'b0;
      tlp_type     = 2'b00;
      tlp_has_data = 1'b0;
      tlp_len      = 10'd0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(pend_empty === 1'b1 && ph_cr === 1'b0 && pd_cr === 1'b0 &&
               nph_cr === 1'b0 && npd_cr === 1'b0) && n < 6000) begin
         tick();
         n++;
      end
      nvec++;
      if (n >= 6000) begin
         nerr++;
         $display("FAIL wait_idle: pend_empty=%b after %0d cycles, required 1", pend_empty, n);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      quiet();
      repeat (3) tick();
      nvec++;
      if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow} !== 6'b000010) begin
         nerr++;
         $display("FAIL reset_hold: outs=%b required 000010",
                  {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow});
      end
      rst = 1'b0;
      repeat (2) tick();
      nvec++;
      if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow} !== 6'b000010) begin
         nerr++;
         $display("FAIL reset_release: outs=%b required 000010",
                  {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow});
      end
   endtask

   task automatic test_np_single();
      drive(2'b01, 1'b0, 10'd4);
      tick();
      quiet();
      nvec++;
      if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty} !== 5'b00100) begin
         nerr++;
         $display("FAIL np_single_n1: outs=%b required 00100",
                  {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty});
      end
      tick();
      nvec++;
      if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty} !== 5'b00001) begin
         nerr++;
         $display("FAIL np_single_n2: outs=%b required 00001",
                  {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty});
      end
   endtask

   task automatic test_pd_batch();
      drive(2'b00, 1'b1, 10'd16);
      tick();
      quiet();
      nvec++;
      if (ph_cr !== 1'b1 || pd_cr !== 1'b0) begin
         nerr++;
         $display("FAIL batch_first: ph_cr=%b pd_cr=%b required 1 0", ph_cr, pd_cr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (pd_cr !== 1'b0 || pend_empty !== 1'b0) begin
            nerr++;
            $display("FAIL batch_hold[%0d]: pd_cr=%b pend_empty=%b required 0 0", i, pd_cr, pend_empty);
         end
      end
      drive(2'b00, 1'b1, 10'd20);
      tick();
      quiet();
      for (int i = 0; i < 11; i++) begin
         nvec++;
         if (pd_cr !== (i < 9)) begin
            nerr++;
            $display("FAIL batch_drain[%0d]: pd_cr=%b required %b", i, pd_cr, (i < 9));
         end
         tick();
      end
   endtask

   task automatic test_flush();
      drive(2'b00, 1'b1, 10'd1);
      for (int k = 1; k <= 70; k++) begin
         tick();
         quiet();
         nvec++;
         if (pd_cr !== (k == 65)) begin
            nerr++;
            $display("FAIL flush[N+%0d]: pd_cr=%b required %b", k, pd_cr, (k == 65));
         end
      end
   endtask

   task automatic test_max_len();
      drive(2'b00, 1'b1, 10'd0);
      for (int k = 1; k <= 260; k++) begin
         tick();
         quiet();
         nvec++;
         if (pd_cr !== (k >= 2 && k <= 257)) begin
            nerr++;
            $display("FAIL max_len[N+%0d]: pd_cr=%b required %b", k, pd_cr, (k >= 2 && k <= 257));
         end
      end
   endtask

   task automatic test_drain_inc();
      drive(2'b00, 1'b1, 10'd32);
      for (int k = 1; k <= 14; k++) begin
         tick();
         quiet();
         nvec++;
         if (pd_cr !== (k >= 2 && k <= 11) || ph_cr !== (k == 1 || k == 5)) begin
            nerr++;
            $display("FAIL drain_inc[N+%0d]: pd_cr=%b ph_cr=%b required %b %b", k, pd_cr, ph_cr,
                     (k >= 2 && k <= 11), (k == 1 || k == 5));
         end
         if (k == 4) begin
            drive(2'b00, 1'b1, 10'd8);
         end
      end
   endtask

   task automatic test_cpl();
      drive(2'b10, 1'b1, 10'd16);
      tick();
      drive(2'b11, 1'b1, 10'd64);
      tick();
      quiet();
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty} !== 5'b00001) begin
            nerr++;
            $display("FAIL cpl[%0d]: outs=%b required 00001", k,
                     {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty});
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      drive(2'b01, 1'b1, 10'd1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k < 3) begin
            drive(2'b01, 1'b1, 10'd1);
         end else begin
            quiet();
         end
         nvec++;
         if (nph_cr !== (k <= 3) || npd_cr !== (k <= 3) || pend_empty !== (k > 3)) begin
            nerr++;
            $display("FAIL b2b[N+%0d]: nph=%b npd=%b empty=%b required %b %b %b", k,
                     nph_cr, npd_cr, pend_empty, (k <= 3), (k <= 3), (k > 3));
         end
      end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 20; k++) begin
         drive(2'b00, 1'b1, 10'd0);
         tick();
      end
      quiet();
      tick();
      nvec++;
      if (cr_overflow !== 1'b1) begin
         nerr++;
         $display("FAIL ovf_set: cr_overflow=%b required 1", cr_overflow);
      end
      repeat (50) tick();
      nvec++;
      if (cr_overflow !== 1'b1 || pd_cr !== 1'b1) begin
         nerr++;
         $display("FAIL ovf_sticky: cr_overflow=%b pd_cr=%b required 1 1", cr_overflow, pd_cr);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if ({ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow} !== 6'b000010) begin
         nerr++;
         $display("FAIL ovf_rst: outs=%b required 000010",
                  {ph_cr, pd_cr, nph_cr, npd_cr, pend_empty, cr_overflow});
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         nvec++;
         if (pd_cr !== 1'b0 || pend_empty !== 1'b1 || cr_overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_discard[%0d]: pd_cr=%b empty=%b ovf=%b required 0 1 0", k,
                     pd_cr, pend_empty, cr_overflow);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      quiet();
      test_reset();
      test_np_single();
      wait_idle();
      test_pd_batch();
      wait_idle();
      test_flush();
      wait_idle();
      test_max_len();
      wait_idle();
      test_drain_inc();
      wait_idle();
      test_cpl();
      wait_idle();
      test_back_to_back();
      wait_idle();
      test_overflow();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
